// File: rtl/seq_alu.sv
// Registered execute-stage ALU with iterative multiply and restoring divide.
// Multi-cycle ops run one bit per edge behind a start/busy/done handshake.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_EQ   = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;
    localparam logic [3:0] OP_REMU = 4'b1110;
    localparam logic [3:0] OP_PASS = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] out_q;
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;

    // MUL: a_q = shifted multiplicand, b_q = shifted multiplier, acc_q = partial sum.
    // DIV: a_q = divisor, q_q = dividend/quotient, acc_q = partial remainder.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] q_q;
    logic             rem_sel_q;
    logic [SHW-1:0]   cnt_q;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             is_multi;
    logic             last;

    logic [WIDTH-1:0] mul_acc_d;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_d;
    logic [WIDTH-1:0] div_quo_d;

    logic             wr_en;
    logic [WIDTH-1:0] wr_val;
    logic             wr_ovf;

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;
    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;

    assign shamt    = inp2[SHW-1:0];
    assign sum      = inp1 + inp2;
    assign dif      = inp1 - inp2;
    assign is_multi = (sel == OP_MUL) || (sel == OP_DIVU) || (sel == OP_REMU);
    assign last     = (cnt_q == {SHW{1'b1}});

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (sel)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (inp1[WIDTH-1] == inp2[WIDTH-1]) &&
                          (sum[WIDTH-1] != inp1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif;
                alu_ovf = (inp1[WIDTH-1] != inp2[WIDTH-1]) &&
                          (dif[WIDTH-1] != inp1[WIDTH-1]);
            end
            OP_AND:  alu_res = inp1 & inp2;
            OP_OR:   alu_res = inp1 | inp2;
            OP_NOR:  alu_res = ~(inp1 | inp2);
            OP_XOR:  alu_res = inp1 ^ inp2;
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, inp1 == inp2};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, inp1 < inp2};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(inp1) < $signed(inp2)};
            OP_SLL:  alu_res = inp1 << shamt;
            OP_SRL:  alu_res = inp1 >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(inp1) >>> shamt);
            OP_PASS: alu_res = inp2;
            default: alu_res = '0;
        endcase
    end

    // Shift-add step and restoring-division step share the iteration counter.
    always_comb begin
        mul_acc_d = acc_q + (b_q[0] ? a_q : '0);
        div_sh    = {acc_q, q_q[WIDTH-1]};
        div_diff  = div_sh - {1'b0, a_q};
        div_ge    = ~div_diff[WIDTH];
        div_rem_d = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
        div_quo_d = {q_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        wr_en  = 1'b0;
        wr_val = '0;
        wr_ovf = 1'b0;
        unique case (state_q)
            IDLE: begin
                wr_en  = start && !is_multi;
                wr_val = alu_res;
                wr_ovf = alu_ovf;
            end
            MUL: begin
                wr_en  = last;
                wr_val = mul_acc_d;
            end
            DIV: begin
                wr_en  = last;
                wr_val = rem_sel_q ? div_rem_d : div_quo_d;
            end
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            out_q     <= '0;
            zero_q    <= 1'b1;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            rem_sel_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            done_q <= wr_en;
            if (wr_en) begin
                out_q  <= wr_val;
                zero_q <= (wr_val == '0);
                neg_q  <= wr_val[WIDTH-1];
                ovf_q  <= wr_ovf;
            end
            unique case (state_q)
                IDLE: begin
                    if (start && sel == OP_MUL) begin
                        a_q     <= inp1;
                        b_q     <= inp2;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MUL;
                    end else if (start && is_multi) begin
                        a_q       <= inp2;
                        q_q       <= inp1;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        rem_sel_q <= (sel == OP_REMU);
                        busy_q    <= 1'b1;
                        state_q   <= DIV;
                    end
                end
                MUL: begin
                    acc_q <= mul_acc_d;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + SHW'(1);
                    if (last) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                DIV: begin
                    acc_q <= div_rem_d;
                    q_q   <= div_quo_d;
                    cnt_q <= cnt_q + SHW'(1);
                    if (last) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu at WIDTH=32 and WIDTH=8,
// checked against an arithmetic reference model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        st;
    logic [3:0]  sel_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    int          w;

    logic        start32, busy32, done32, zero32, neg32, ovf32;
    logic [31:0] out32;
    logic        start8, busy8, done8, zero8, neg8, ovf8;
    logic [7:0]  out8;

    logic        cur_busy, cur_done, cur_zero, cur_neg, cur_ovf;
    logic [31:0] cur_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign start32 = st && (w == 32);
    assign start8  = st && (w == 8);

    seq_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .sel(sel_i),
        .inp1(a_i), .inp2(b_i), .busy(busy32), .done(done32),
        .out(out32), .zero(zero32), .neg(neg32), .ovf(ovf32)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sel(sel_i),
        .inp1(a_i[7:0]), .inp2(b_i[7:0]), .busy(busy8), .done(done8),
        .out(out8), .zero(zero8), .neg(neg8), .ovf(ovf8)
    );

    always_comb begin
        cur_busy = busy32;
        cur_done = done32;
        cur_out  = out32;
        cur_zero = zero32;
        cur_neg  = neg32;
        cur_ovf  = ovf32;
        if (w == 8) begin
            cur_busy = busy8;
            cur_done = done8;
            cur_out  = {24'b0, out8};
            cur_zero = zero8;
            cur_neg  = neg8;
            cur_ovf  = ovf8;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input int wd, input logic [3:0] s,
                                  input logic [63:0] ai, input logic [63:0] bi,
                                  output logic [63:0] r, output logic o);
        logic [63:0] m;
        logic [63:0] a;
        logic [63:0] b;
        longint      sa;
        longint      sb;
        int          sh;
        m  = (64'd1 << wd) - 64'd1;
        a  = ai & m;
        b  = bi & m;
        sa = a[wd-1] ? longint'(a) - longint'(64'd1 << wd) : longint'(a);
        sb = b[wd-1] ? longint'(b) - longint'(64'd1 << wd) : longint'(b);
        sh = int'(b[31:0]) & (wd - 1);
        o  = 1'b0;
        case (s)
            4'd0: begin
                r = (a + b) & m;
                o = (a[wd-1] == b[wd-1]) && (r[wd-1] != a[wd-1]);
            end
            4'd1: begin
                r = (a - b) & m;
                o = (a[wd-1] != b[wd-1]) && (r[wd-1] != a[wd-1]);
            end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = ~(a | b) & m;
            4'd5:  r = a ^ b;
            4'd6:  r = (a == b) ? 64'd1 : 64'd0;
            4'd7:  r = (a < b) ? 64'd1 : 64'd0;
            4'd8:  r = (sa < sb) ? 64'd1 : 64'd0;
            4'd9:  r = (a << sh) & m;
            4'd10: r = a >> sh;
            4'd11: r = 64'(sa >>> sh) & m;
            4'd12: r = (a * b) & m;
            4'd13: r = (b == 0) ? m : a / b;
            4'd14: r = (b == 0) ? a : a % b;
            default: r = b;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] er;
        logic        eo;
        int          n;
        int          nb;
        bit          multi;
        model(w, s, 64'(a), 64'(b), er, eo);
        multi = (s == 4'hC) || (s == 4'hD) || (s == 4'hE);
        @(negedge clk);
        sel_i = s;
        a_i   = a;
        b_i   = b;
        st    = 1'b1;
        @(posedge clk);
        #1 st = 1'b0;
        n  = 0;
        nb = 0;
        while (!cur_done && n < 200) begin
            if (cur_busy) nb++;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), multi ? 64'(w) : 64'd0);
        check({tag, " busy"}, 64'(nb), multi ? 64'(w) : 64'd0);
        check({tag, " out"}, 64'(cur_out), er);
        check({tag, " zero"}, 64'(cur_zero), 64'(er == 64'd0));
        check({tag, " neg"}, 64'(cur_neg), 64'(er[w-1]));
        check({tag, " ovf"}, 64'(cur_ovf), 64'(eo));
    endtask

    initial begin
        logic [3:0]  rs;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] er;
        logic        eo;
        logic [31:0] held;
        int          n;
        int          extra;

        w     = 32;
        rst   = 1'b1;
        st    = 1'b0;
        sel_i = '0;
        a_i   = '0;
        b_i   = '0;
        #12 rst = 1'b0;
        #1;
        check("rst busy", 64'(busy32), 64'd0);
        check("rst done", 64'(done32), 64'd0);
        check("rst out", 64'(out32), 64'd0);
        check("rst zero", 64'(zero32), 64'd1);
        check("rst neg", 64'(neg32), 64'd0);
        check("rst ovf", 64'(ovf32), 64'd0);

        // reset in the middle of a multiply
        run_op("pre add", 4'h0, 32'd2, 32'd3);
        @(negedge clk);
        sel_i = 4'hC; a_i = 32'd1234; b_i = 32'd99; st = 1'b1;
        @(posedge clk);
        #1 st = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst busy", 64'(busy32), 64'd0);
        check("midrst out", 64'(out32), 64'd0);
        check("midrst zero", 64'(zero32), 64'd1);
        @(negedge clk) rst = 1'b0;
        run_op("post add", 4'h0, 32'd2, 32'd3);

        run_op("add ovf", 4'h0, 32'h7FFF_FFFF, 32'd1);
        run_op("sub zero", 4'h1, 32'd5, 32'd5);
        run_op("slt", 4'h8, 32'hFFFF_FFFF, 32'd1);
        run_op("sltu", 4'h7, 32'hFFFF_FFFF, 32'd1);
        run_op("sra", 4'hB, 32'h8000_0000, 32'd4);
        run_op("nor", 4'h4, 32'd0, 32'd0);
        run_op("sub ovf", 4'h1, 32'h8000_0000, 32'd1);
        run_op("mul", 4'hC, 32'd12345, 32'd678);
        run_op("divu", 4'hD, 32'd100, 32'd7);
        run_op("remu", 4'hE, 32'd100, 32'd7);
        run_op("divu0", 4'hD, 32'd9, 32'd0);
        run_op("remu0", 4'hE, 32'd9, 32'd0);
        run_op("eq", 4'h6, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        run_op("pass", 4'hF, 32'd1, 32'hCAFE_0000);

        // start pulsed while busy must be ignored
        @(negedge clk);
        sel_i = 4'hC; a_i = 32'd300; b_i = 32'd7; st = 1'b1;
        @(posedge clk);
        #1 st = 1'b0;
        n = 0;
        repeat (10) begin
            @(posedge clk);
            #1 n++;
        end
        sel_i = 4'h0; a_i = 32'd1; b_i = 32'd1; st = 1'b1;
        @(posedge clk);
        #1 st = 1'b0;
        n++;
        while (!done32 && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        check("ign latency", 64'(n), 64'd32);
        check("ign out", 64'(out32), 64'd2100);
        held  = out32;
        extra = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done32) extra++;
        end
        check("ign extra done", 64'(extra), 64'd0);
        check("ign hold", 64'(out32), 64'(held));

        // back-to-back single-cycle ops
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            rs = 4'($urandom_range(0, 11));
            ra = $urandom;
            rb = $urandom;
            sel_i = rs; a_i = ra; b_i = rb; st = 1'b1;
            model(32, rs, 64'(ra), 64'(rb), er, eo);
            @(posedge clk);
            #1;
            check("b2b done", 64'(done32), 64'd1);
            check("b2b out", 64'(out32), er);
        end
        st = 1'b0;

        for (int i = 0; i < 30; i++) begin
            rs = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            run_op("rnd32", rs, ra, rb);
        end

        w = 8;
        run_op("mul8", 4'hC, 32'd15, 32'd17);
        run_op("sll8", 4'h9, 32'h11, 32'h0B);
        run_op("add8 ovf", 4'h0, 32'h7F, 32'h01);
        run_op("divu8 0", 4'hD, 32'd9, 32'd0);
        for (int i = 0; i < 25; i++) begin
            rs = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            run_op("rnd8", rs, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
